// File: rtl/micro_sequencer.sv
// Micro-program sequencer: holds the micro-PC, fetches from a synchronous control-store ROM
// and issues micro-instructions to the decoder. Define MICRO_STACK_EN for call/return support.
module micro_sequencer #(
  parameter int MINST_WIDTH       = 44,
  parameter int BRANCH_ADDR_WIDTH = 10,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [BRANCH_ADDR_WIDTH-1:0] entry_addr_i,
  input  logic                         flush_i,
  input  logic                         cond_flag_i,
  input  logic                         stall_i,
  output logic                         rom_en_o,
  output logic [BRANCH_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [MINST_WIDTH-1:0]       rom_data_i,
  output logic [MINST_WIDTH-1:0]       m_instruction_o,
  output logic                         minst_valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         stack_err_o
);

  localparam logic [2:0] TypeBranch = 3'b011;
  localparam logic [2:0] TypeJump   = 3'b100;
  localparam logic [2:0] TypeEnd    = 3'b111;

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, ISSUE} state_e;

  state_e                         state_q, state_d;
  logic [BRANCH_ADDR_WIDTH-1:0]   upc_q, upc_d, upc_inc, target;
  logic [MINST_WIDTH-1:0]         ir_q, ir_d;
  logic                           valid_q, valid_d;
  logic                           done_q, done_d;
  logic [2:0]                     itype;

  assign itype   = ir_q[MINST_WIDTH-1 -: 3];
  assign target  = ir_q[10 +: BRANCH_ADDR_WIDTH];
  assign upc_inc = upc_q + BRANCH_ADDR_WIDTH'(1);

`ifdef MICRO_STACK_EN
  localparam logic [2:0] TypeCall = 3'b101;
  localparam logic [2:0] TypeRet  = 3'b110;
  localparam int IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SpW  = $clog2(STACK_DEPTH + 1);
  localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

  logic [BRANCH_ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [SpW-1:0]               sp_q;
  logic [IdxW-1:0]              wr_idx, rd_idx;
  logic                         push, pop, err_q, err_d;

  assign wr_idx = IdxW'(sp_q);
  assign rd_idx = IdxW'(sp_q - SpW'(1));
`endif

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef MICRO_STACK_EN
    push  = 1'b0;
    pop   = 1'b0;
    err_d = err_q;
`endif
    if (flush_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            upc_d   = entry_addr_i;
            state_d = FETCH;
`ifdef MICRO_STACK_EN
            err_d = 1'b0;
`endif
          end
        end
        FETCH: state_d = CAPTURE;
        CAPTURE: begin
          ir_d    = rom_data_i;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
        ISSUE: begin
          if (!stall_i) begin
            valid_d = 1'b0;
            state_d = FETCH;
            case (itype)
              TypeJump:   upc_d = target;
              TypeBranch: upc_d = cond_flag_i ? target : upc_inc;
              TypeEnd: begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
`ifdef MICRO_STACK_EN
              TypeCall: begin
                upc_d = target;
                if (sp_q == SpFull) err_d = 1'b1;
                else                push  = 1'b1;
              end
              TypeRet: begin
                if (sp_q == '0) begin
                  err_d = 1'b1;
                  upc_d = upc_inc;
                end else begin
                  pop   = 1'b1;
                  upc_d = stack_q[rd_idx];
                end
              end
`endif
              default: upc_d = upc_inc;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      upc_q   <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef MICRO_STACK_EN
  // The stack is emptied whenever the sequencer sits in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_q == IDLE) sp_q <= '0;
      else if (push)       sp_q <= sp_q + SpW'(1);
      else if (pop)        sp_q <= sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) stack_q[wr_idx] <= upc_inc;
  end

  assign stack_err_o = err_q;
`else
  // Without stack storage the flag is constant zero.
  assign stack_err_o = (STACK_DEPTH < 0);
`endif

  assign rom_en_o        = (state_q == FETCH);
  assign rom_addr_o      = upc_q;
  assign m_instruction_o = ir_q;
  assign minst_valid_o   = valid_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: random and directed programs checked against a
// program-level reference model of micro-PC sequencing and issue timing.
module tb_micro_sequencer;

  localparam int MW    = 44;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start, flush, condFlag, stall;
  logic [AW-1:0] entryAddr;
  logic          romEn;
  logic [AW-1:0] romAddr;
  logic [MW-1:0] romData;
  logic [MW-1:0] mInstruction;
  logic          minstValid, busy, done, stackErr;

  logic [MW-1:0] rom [1024];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: whether a routine is running, cycles since the last fetch launch,
  // the address of the instruction in flight, the return stack and the sticky error.
  bit mRunning;
  int mSince;
  int mPc;
  bit mDone;
  bit mErr;
  int mStack[$];

  int cycle;
  int t0;
  int firstValid;
  int doneCnt;
  int fetchLog[$];

  micro_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .start_i        (start),
    .entry_addr_i   (entryAddr),
    .flush_i        (flush),
    .cond_flag_i    (condFlag),
    .stall_i        (stall),
    .rom_en_o       (romEn),
    .rom_addr_o     (romAddr),
    .rom_data_i     (romData),
    .m_instruction_o(mInstruction),
    .minst_valid_o  (minstValid),
    .busy_o         (busy),
    .done_o         (done),
    .stack_err_o    (stackErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (romEn) romData <= rom[romAddr];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [MW-1:0] mkInstr(input logic [2:0] t, input logic [AW-1:0] tgt);
    logic [20:0] mid;
    logic [9:0]  low;
    mid = 21'($urandom);
    low = 10'($urandom);
    return {t, mid, tgt, low};
  endfunction

  function automatic int logAt(input int i);
    return (i < fetchLog.size()) ? fetchLog[i] : -1;
  endfunction

  task automatic checkAll();
    bit expFetch, expValid;
    expFetch = mRunning && (mSince == 1);
    expValid = mRunning && (mSince >= 3);
    checkOutput("busy", busy, 64'(mRunning));
    checkOutput("romEn", romEn, 64'(expFetch));
    if (expFetch) checkOutput("romAddr", romAddr, 64'(mPc));
    checkOutput("minstValid", minstValid, 64'(expValid));
    if (expValid) checkOutput("mInstruction", mInstruction, rom[mPc]);
    checkOutput("done", done, 64'(mDone));
    checkOutput("stackErr", stackErr, 64'(mErr));
  endtask

  task automatic modelAccept(input bit c);
    logic [MW-1:0] instr;
    logic [2:0]    t;
    int            tgt, nxt;
    instr = rom[mPc];
    t     = instr[43:41];
    tgt   = int'(instr[19:10]);
    nxt   = (mPc + 1) % 1024;
    mSince = 1;
    case (t)
      3'b111: begin mRunning = 0; mDone = 1; end
      3'b100: mPc = tgt;
      3'b011: mPc = c ? tgt : nxt;
`ifdef MICRO_STACK_EN
      3'b101: begin
        if (mStack.size() == DEPTH) mErr = 1;
        else mStack.push_back(nxt);
        mPc = tgt;
      end
      3'b110: begin
        if (mStack.size() == 0) begin mErr = 1; mPc = nxt; end
        else mPc = mStack.pop_back();
      end
`endif
      default: mPc = nxt;
    endcase
  endtask

  task automatic applyStimulus(input bit s, input logic [AW-1:0] e, input bit f, input bit st, input bit c);
    start = s; entryAddr = e; flush = f; stall = st; condFlag = c;
    mDone = 0;
    if (f) mRunning = 0;
    else if (!mRunning) begin
      if (s) begin
        mRunning = 1; mSince = 1; mPc = int'(e); mErr = 0;
        mStack.delete();
      end
    end else if (mSince >= 3 && !st) modelAccept(c);
    else mSince++;
    @(negedge clk);
    cycle++;
    checkAll();
    if (romEn) fetchLog.push_back(int'(romAddr));
    if (done) doneCnt++;
    if (minstValid && firstValid < 0) firstValid = cycle - t0;
  endtask

  task automatic launch(input logic [AW-1:0] e);
    fetchLog.delete();
    doneCnt = 0; firstValid = -1; t0 = cycle;
    applyStimulus(1'b1, e, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runFree(input int n, input int stallPct, input int condMode, input bit startRand, input int flushPct);
    for (int i = 0; i < n; i++) begin
      bit s, c;
      s = startRand && ($urandom_range(0, 3) == 0);
      c = (condMode == 2) ? 1'($urandom) : 1'(condMode);
      applyStimulus(s, AW'($urandom), $urandom_range(0, 99) < flushPct,
                    $urandom_range(0, 99) < stallPct, c);
    end
  endtask

  task automatic doReset();
    rstN = 1'b0;
    mRunning = 0; mDone = 0; mErr = 0; mStack.delete();
    #1;
    checkAll();
    checkOutput("resetInstr", mInstruction, '0);
    checkOutput("resetAddr", romAddr, '0);
    @(negedge clk);
    cycle++;
    checkAll();
    rstN = 1'b1;
  endtask

  initial begin
    logic [MW-1:0] held;
    start = 0; flush = 0; condFlag = 0; stall = 0; entryAddr = '0; romData = '0;
    cycle = 0; t0 = 0; firstValid = -1; doneCnt = 0;
    for (int i = 0; i < 1024; i++) rom[i] = mkInstr(3'b000, '0);
    @(negedge clk);
    doReset();

    // Straight-line routine of three instructions.
    rom[10'h010] = mkInstr(3'b000, AW'($urandom));
    rom[10'h011] = mkInstr(3'b000, AW'($urandom));
    rom[10'h012] = mkInstr(3'b111, AW'($urandom));
    launch(10'h010);
    runFree(12, 0, 0, 0, 0);
    checkOutput("firstValid", 64'(firstValid), 3);
    checkOutput("doneCount", 64'(doneCnt), 1);
    checkOutput("thirdFetch", 64'(logAt(2)), 10'h012);
    checkOutput("fetchCount", 64'(fetchLog.size()), 3);

    // Unconditional jump.
    rom[10'h010] = mkInstr(3'b100, 10'h200);
    rom[10'h200] = mkInstr(3'b111, '0);
    launch(10'h010);
    runFree(10, 0, 0, 0, 0);
    checkOutput("jumpTarget", 64'(logAt(1)), 10'h200);

    // Conditional branch, taken and not taken.
    rom[10'h010] = mkInstr(3'b011, 10'h050);
    rom[10'h050] = mkInstr(3'b111, '0);
    rom[10'h011] = mkInstr(3'b111, '0);
    launch(10'h010);
    runFree(10, 0, 1, 0, 0);
    checkOutput("branchTaken", 64'(logAt(1)), 10'h050);
    launch(10'h010);
    runFree(10, 0, 0, 0, 0);
    checkOutput("branchNotTaken", 64'(logAt(1)), 10'h011);

    // Four stall cycles in ISSUE.
    rom[10'h030] = mkInstr(3'b000, '0);
    rom[10'h031] = mkInstr(3'b111, '0);
    launch(10'h030);
    applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    held = mInstruction;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 0, 1, 0);
      checkOutput("stallHold", mInstruction, rom[10'h030]);
    end
    checkOutput("stallHeldStart", held, rom[10'h030]);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("resumeFetch", romEn, 1);
    runFree(6, 0, 0, 0, 0);

    // Micro-PC wrap.
    rom[10'h3FF] = mkInstr(3'b000, '0);
    rom[10'h000] = mkInstr(3'b111, '0);
    launch(10'h3FF);
    runFree(10, 0, 0, 0, 0);
    checkOutput("wrapFetch", 64'(logAt(1)), 10'h000);

    // Flush in ISSUE together with an accept.
    rom[10'h040] = mkInstr(3'b111, '0);
    launch(10'h040);
    applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0);
    applyStimulus(1, 10'h040, 1, 0, 0);
    checkOutput("flushBusy", busy, 0);
    checkOutput("flushDone", done, 0);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("flushNoFetch", romEn, 0);

    // Reset during CAPTURE, then start while busy.
    rom[10'h080] = mkInstr(3'b000, '0);
    rom[10'h081] = mkInstr(3'b111, '0);
    launch(10'h080);
    applyStimulus(0, '0, 0, 0, 0);
    doReset();
    launch(10'h080);
    applyStimulus(1, 10'h123, 0, 0, 0);
    runFree(8, 0, 0, 0, 0);
    checkOutput("busyStartIgnored", 64'(logAt(1)), 10'h081);

`ifdef MICRO_STACK_EN
    rom[10'h020] = mkInstr(3'b101, 10'h100);
    rom[10'h100] = mkInstr(3'b110, '0);
    rom[10'h021] = mkInstr(3'b111, '0);
    launch(10'h020);
    runFree(12, 0, 0, 0, 0);
    checkOutput("callTarget", 64'(logAt(1)), 10'h100);
    checkOutput("returnAddr", 64'(logAt(2)), 10'h021);

    for (int i = 0; i < 5; i++) rom[10'h060 + 16 * i] = mkInstr(3'b101, AW'(10'h070 + 16 * i));
    rom[10'h0B0] = mkInstr(3'b111, '0);
    launch(10'h060);
    runFree(20, 0, 0, 0, 0);
    checkOutput("overflowErr", stackErr, 1);

    rom[10'h0C0] = mkInstr(3'b110, '0);
    rom[10'h0C1] = mkInstr(3'b111, '0);
    launch(10'h0C0);
    runFree(8, 0, 0, 0, 0);
    checkOutput("underflowNext", 64'(logAt(1)), 10'h0C1);
    checkOutput("underflowErr", stackErr, 1);
`endif

    // Random programs with random stall, condition, start and flush.
    for (int iter = 0; iter < 20; iter++) begin
      for (int a = 0; a < 1024; a++) begin
        int r;
        logic [2:0] t;
        r = $urandom_range(0, 15);
        if (r < 2)       t = 3'b111;
        else if (r < 4)  t = 3'b100;
        else if (r < 6)  t = 3'b011;
        else if (r == 6) t = 3'b101;
        else if (r == 7) t = 3'b110;
        else             t = 3'($urandom_range(0, 2));
        rom[a] = mkInstr(t, AW'($urandom));
      end
      launch(AW'($urandom));
      runFree(60, 30, 2, 1, 3);
      applyStimulus(0, '0, 1, 0, 0);
      applyStimulus(0, '0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Micro-program sequencer that sits directly upstream of the micro-instruction decoder. It holds the micro-PC, fetches 44-bit micro-instructions from a synchronous control-store ROM, and presents each one to the decoder with a valid/stall handshake. It resolves next-address selection (sequential, jump, conditional branch, end, optional call/return) from the instruction's type and branch-target fields.

## Interface
- MINST_WIDTH, 44, micro-instruction width. Type field is [43:41] and branch target is [19:10].
- BRANCH_ADDR_WIDTH, 10, micro-PC and ROM address width.
- STACK_DEPTH, 4, call-stack entries. Used only with MICRO_STACK_EN.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a micro-routine at entry_addr. Honoured only in IDLE.
- entry_addr  in  BRANCH_ADDR_WIDTH  micro-routine start address
- flush  in  1  synchronous abort to IDLE
- cond_flag  in  1  condition for type 3'b011 branches
- stall  in  1  decoder/execute not ready
- rom_en  out  1  ROM read strobe
- rom_addr  out  BRANCH_ADDR_WIDTH  ROM address (registered micro-PC)
- rom_data  in  MINST_WIDTH  ROM read data, valid the cycle after rom_en
- m_instruction  out  MINST_WIDTH  registered micro-instruction to decoder
- minst_valid  out  1  m_instruction valid
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when an end instruction is accepted
- stack_err  out  1  sticky stack over/underflow flag

## Operation
- **States:** IDLE, FETCH, CAPTURE, ISSUE.
- **IDLE:**
  - When start=1, load upc ← entry_addr and go to FETCH.
  - Clear stack_err and empty the stack.
- **FETCH:** rom_en=1, rom_addr=upc. Go to CAPTURE.
- **CAPTURE:** load ir ← rom_data. Go to ISSUE.
- **ISSUE:**
  - minst_valid=1 and m_instruction=ir. Both are held unchanged while stall=1.
  - When stall=0, the instruction is accepted and the sequencer computes the next address from ir[43:41] as below.
- **Next-address selection on accept:**
  - 3'b100 (jump): upc ← ir[19:10], go to FETCH.
  - 3'b011 (conditional branch): upc ← ir[19:10] if cond_flag=1, else upc+1; go to FETCH. cond_flag is sampled in the accept cycle.
  - 3'b111 (end): done=1 for the next cycle, go to IDLE.
  - Any other type: upc ← upc+1, go to FETCH.
- **Arithmetic:** upc+1 is modulo 2^BRANCH_ADDR_WIDTH, so 0x3FF wraps to 0x000.
- **flush:** flush=1 in any state forces IDLE next cycle and clears minst_valid. flush has priority over start and over accept.
- **start while busy:** ignored.
- **Reset values:** state=IDLE, upc=0, ir=0, minst_valid=0, rom_en=0, busy=0, done=0, stack_err=0.
- **Reset mid-operation:** returns to the reset values immediately (asynchronous). No partial instruction is ever presented.

## Timing
- **Start latency:** start sampled at edge 0 → rom_en high in cycle 1 → minst_valid high in cycle 3.
- **Throughput:** 3 cycles per instruction with no stall. Each stall cycle adds one cycle.
- **Outputs:** minst_valid and m_instruction are registered. rom_en and busy decode the state register. rom_addr is upc.
- **done:** asserted exactly one cycle, the cycle after the end instruction is accepted; the state is IDLE in that same cycle.

## Configuration
- **Macro:** MICRO_STACK_EN.
- **Defined:**
  - 3'b101 (call) pushes upc+1 and sets upc ← ir[19:10].
  - 3'b110 (return) pops into upc.
  - Call with STACK_DEPTH entries already held sets stack_err=1, pushes nothing, and still jumps.
  - Return with the stack empty sets stack_err=1 and uses upc+1.
  - stack_err clears only on reset or a start from IDLE.
- **Undefined:** no stack storage; stack_err is tied 0. Types 3'b101 and 3'b110 sequence as upc+1.

## Test plan
- **Straight line:** start, entry 0x010; ROM holds types 000,000,111 → instructions from 0x010, 0x011, 0x012 issued with minst_valid first in cycle 3, one instruction every 3 cycles; done pulses once; busy drops.
- **Branches:**
  - Type 100, target 0x200 at 0x010 → next fetch address is 0x200.
  - Type 011, target 0x050: cond_flag=1 → 0x050; cond_flag=0 → 0x011.
- **Stall:** hold stall=1 for 4 cycles in ISSUE → m_instruction stable, minst_valid=1, rom_en=0; fetch resumes 1 cycle after stall falls.
- **Wrap and flush:** entry 0x3FF, type 000 → next fetch 0x000. flush asserted in ISSUE together with stall=0 → IDLE, no fetch, done=0.
- **Reset and start:** rst_n low during CAPTURE → all outputs at reset values the same cycle. start asserted while busy → ignored.
- **MICRO_STACK_EN:**
  - Call 0x100 from 0x020, then return → fetch 0x100, then 0x021.
  - 5 nested calls with depth 4 → stack_err=1.
  - Return on an empty stack → stack_err=1 and next address upc+1.
